// File: rtl/mio_arbiter.sv
// Two-requester round-robin arbiter for a single memory/I/O port.
// Aborts a transaction with an err pulse when mem_r does not arrive within TIMEOUT BUSY cycles.
module mio_arbiter #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rw,
   output logic          mem_en,
   input  logic          mem_r,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StRecover} state_e;

   localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          grant1;
   logic [15:0]   cnt_q, cnt_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_rw_q, mem_rw_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          err0_q, err0_d, err1_q, err1_d;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      err0_d      = 1'b0;
      err1_d      = 1'b0;
      // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
      grant1      = req1 & (~req0 | ~last_q);

      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d     = StBusy;
               mem_en_d    = 1'b1;
               owner_d     = grant1;
               last_d      = grant1;
               cnt_d       = '0;
               mem_rw_d    = grant1 ? we1 : we0;
               mem_addr_d  = grant1 ? addr1 : addr0;
               mem_wdata_d = grant1 ? wdata1 : wdata0;
            end
         end
         StBusy: begin
            mem_en_d = 1'b1;
            if (mem_r) begin
               state_d  = StRecover;
               mem_en_d = 1'b0;
               ack0_d   = ~owner_q;
               ack1_d   = owner_q;
               if (!mem_rw_q) rdata_d = mem_rdata;
            end else if (cnt_q == LastCnt) begin
               state_d  = StRecover;
               mem_en_d = 1'b0;
               err0_d   = ~owner_q;
               err1_d   = owner_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StRecover: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err0      = err0_q;
   assign err1      = err1_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rw    = mem_rw_q;
   assign mem_en    = mem_en_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Randomised bench for mio_arbiter: a transaction-level predictor derives grant order, enable
// window, completion/abort cycle and read data from grant time and responder latency.
module tb_mio_arbiter;
   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int TIMEOUT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, err0, err1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rw, mem_en;
   logic          mem_r;
   logic [DW-1:0] mem_rdata;

   mio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_en(mem_en),
      .mem_r(mem_r), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level predictor state
   int            cyc = 0;
   bit            busy = 0;       // a granted transaction has not yet completed/aborted
   int            g, lat, out_c;  // grant cycle, responder latency, outcome cycle
   int            idle_at = 0;    // first cycle in which requests are honoured again
   bit            own, last_g = 1, dropped, rst_pend, r_hold;
   logic          t_we;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, exp_rdata = '0, rd_val;
   int            force_lat = -1;
   bit            fix_rd_en = 0;
   logic [DW-1:0] fix_rd;
   int            grants[$];
   bit            gown[$];
   int            n_en, n_ack0, n_ack1, n_err0, n_err1;
   logic [AW-1:0] seen_addr;
   logic [DW-1:0] seen_wdata;

   // Responder: mem_r rises lat cycles into BUSY and clears one cycle after mem_en falls.
   task automatic drive_mem();
      if (busy && (cyc - g) >= lat && lat < TIMEOUT) begin
         if (!mem_r) begin
            rd_val    = fix_rd_en ? fix_rd : DW'($urandom);
            mem_rdata = rd_val;
         end
         mem_r = 1'b1;
      end else if (r_hold) begin
         mem_r  = 1'b1;
         r_hold = 1'b0;
      end else begin
         mem_r = 1'b0;
      end
   endtask

   task automatic decide();
      drive_mem();
      rst_pend = rst;
      if (!rst && !busy && cyc >= idle_at && (req0 || req1)) begin
         own     = (req1 && (!req0 || !last_g));
         last_g  = own;
         t_we    = own ? we1 : we0;
         t_addr  = own ? addr1 : addr0;
         t_wdata = own ? wdata1 : wdata0;
         g       = cyc + 1;
         lat     = (force_lat >= 0) ? force_lat : $urandom_range(0, TIMEOUT + 1);
         out_c   = (lat < TIMEOUT) ? g + lat + 1 : g + TIMEOUT;
         busy    = 1;
         dropped = 0;
         grants.push_back(g);
         gown.push_back(own);
      end
   endtask

   task automatic observe();
      logic [3:0] ep = 4'b0000;
      bit         een = 0;
      n_en   += int'(mem_en);
      n_ack0 += int'(ack0);
      n_ack1 += int'(ack1);
      n_err0 += int'(err0);
      n_err1 += int'(err1);
      if (mem_en) begin
         seen_addr  = mem_addr;
         seen_wdata = mem_wdata;
      end
      if (rst_pend) begin
         busy      = 0;
         last_g    = 1;
         exp_rdata = '0;
         idle_at   = cyc;
         r_hold    = 0;
         chk("rst_fields", {mem_rw, mem_addr, mem_wdata}, '0);
      end else if (busy && cyc < out_c) begin
         een = 1;
         chk("busy_fields", {mem_rw, mem_addr, mem_wdata}, {t_we, t_addr, t_wdata});
      end else if (busy && cyc == out_c) begin
         if (lat < TIMEOUT) begin
            ep = own ? 4'b0100 : 4'b1000;
            if (!t_we) exp_rdata = rd_val;
         end else begin
            ep = own ? 4'b0001 : 4'b0010;
         end
         busy    = 0;
         idle_at = cyc + 1;
         r_hold  = (lat < TIMEOUT);
         if (!dropped) begin
            if (own) req1 = 1'b0;
            else req0 = 1'b0;
         end
      end
      chk("mem_en", mem_en, een);
      chk("pulses", {ack0, ack1, err0, err1}, ep);
      chk("rdata", rdata, exp_rdata);
   endtask

   task automatic tick();
      decide();
      @(posedge clk);
      #1;
      cyc++;
      observe();
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((busy || req0 || req1) && n < max) begin
         tick();
         n++;
      end
      if (busy || req0 || req1) begin
         total++;
         bad++;
         $display("FAIL drain: still active after %0d cycles", max);
      end
      tick();
   endtask

   task automatic zero_counts();
      n_en = 0; n_ack0 = 0; n_ack1 = 0; n_err0 = 0; n_err1 = 0;
   endtask

   task automatic new_txn(input int r);
      if (r == 0) begin
         req0 = 1'b1; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
      end else begin
         req1 = 1'b1; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
      end
   endtask

   initial begin
      rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mem_r = 0; mem_rdata = '0; r_hold = 0;
      zero_counts();
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single read with two-cycle responder latency
      zero_counts();
      fix_rd_en = 1; fix_rd = 16'hBEEF; force_lat = 2;
      req0 = 1; we0 = 0; addr0 = 16'h3000;
      drain(30);
      chk("read_addr", seen_addr, 16'h3000);
      chk("read_rdata", rdata, 16'hBEEF);
      chk("read_ack0", n_ack0, 1);
      chk("read_others", n_ack1 + n_err0 + n_err1, 0);
      chk("read_en_cycles", n_en, 3);
      fix_rd_en = 0;

      // Contention: both requesters held, immediate ready
      grants.delete(); gown.delete();
      force_lat = 0;
      req0 = 1; we0 = 0; addr0 = 16'h1111;
      req1 = 1; we1 = 0; addr1 = 16'h2222;
      for (int i = 0; i < 40 && grants.size() < 4; i++) begin
         tick();
         if (grants.size() < 4) begin
            req0 = 1;
            req1 = 1;
         end
      end
      drain(30);
      if (grants.size() >= 4) begin
         chk("rr_first", gown[0], 1'b1);
         for (int i = 1; i < 4; i++) begin
            chk("rr_alt", gown[i], !gown[i-1]);
            chk("rr_spacing", grants[i] - grants[i-1], 3);
         end
      end else begin
         total++; bad++;
         $display("FAIL contention: only %0d grants", grants.size());
      end

      // Write from requester 1
      zero_counts();
      force_lat = 3;
      req1 = 1; we1 = 1; addr1 = 16'hFE06; wdata1 = 16'h0041;
      drain(30);
      chk("write_wdata", seen_wdata, 16'h0041);
      chk("write_ack1", n_ack1, 1);

      // Timeout: responder never answers
      zero_counts();
      force_lat = TIMEOUT + 1;
      req0 = 1; we0 = 0; addr0 = 16'h0404;
      drain(30);
      chk("to_en_cycles", n_en, TIMEOUT);
      chk("to_err0", n_err0, 1);
      chk("to_no_ack", n_ack0, 0);

      // Completion on the last allowed BUSY cycle beats the timeout
      zero_counts();
      force_lat = TIMEOUT - 1;
      req0 = 1; we0 = 0; addr0 = 16'h0505;
      drain(30);
      chk("race_ack0", n_ack0, 1);
      chk("race_err0", n_err0, 0);

      // Reset in the second BUSY cycle
      zero_counts();
      force_lat = TIMEOUT + 1;
      req0 = 1; we0 = 0; addr0 = 16'h0606;
      for (int i = 0; i < 20 && !(busy && cyc == g + 1); i++) tick();
      rst  = 1;
      req1 = 1; we1 = 1; addr1 = 16'h0707;
      tick();
      rst = 0;
      chk("rst_no_pulse", n_ack0 + n_err0 + n_ack1 + n_err1, 0);
      grants.delete(); gown.delete();
      force_lat = 0;
      tick();
      tick();
      if (gown.size() > 0) chk("rst_rr_first", gown[0], 1'b0);
      else begin
         total++; bad++;
         $display("FAIL rst_rr_first: no grant after reset");
      end
      drain(30);

      // Randomised traffic, including requests dropped while their transaction is in flight
      force_lat = -1;
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < 2; r++) begin
            bit rq = (r == 0) ? req0 : req1;
            if (busy && own == r && rq && cyc > g && $urandom_range(0, 19) == 0) begin
               if (r == 0) req0 = 0;
               else req1 = 0;
               dropped = 1;
            end else if (!rq && !(busy && own == r) && $urandom_range(0, 2) == 0) begin
               new_txn(r);
            end
         end
         tick();
      end
      drain(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
